// File: rtl/mod_mult_serial_resp_if.sv
// AXI-stream style bundle carrying tagged beats between the multiexp core and its multipliers.
// The source drives dat/val/sop/eop/err/mod/ctl and the sink returns rdy.
interface if_axi_stream #(
  parameter int DAT_BYTS = 64,
  parameter int CTL_BITS = 16,
  parameter int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
);

  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;

  modport master (
    output dat, val, sop, eop, err, mod, ctl,
    input  rdy
  );

  modport slave (
    input  dat, val, sop, eop, err, mod, ctl,
    output rdy
  );

endinterface

// File: rtl/mod_mult_serial_resp.sv
// Bit-serial (a*b) mod P responder: one request in flight, MSB-first double-and-add,
// result returned with the request tag echoed.
module mod_mult_serial_resp #(
  parameter int                  DAT_BITS = 256,
  parameter int                  CTL_BITS = 16,
  parameter logic [DAT_BITS-1:0] P        = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
  input  logic i_clk,
  input  logic i_rst,
  if_axi_stream.slave  i_mul,
  if_axi_stream.master o_mul
);

  localparam int CNT_BITS = (DAT_BITS > 1) ? $clog2(DAT_BITS) : 1;
  localparam logic [DAT_BITS+1:0] P_X1 = {2'b00, P};
  localparam logic [DAT_BITS+1:0] P_X2 = {1'b0, P, 1'b0};
  localparam logic [CNT_BITS-1:0] CNT_TOP = CNT_BITS'(DAT_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } state_t;

  state_t              state;
  logic [DAT_BITS-1:0] a_reg;
  logic [DAT_BITS-1:0] b_reg;
  logic [DAT_BITS-1:0] acc;
  logic [CTL_BITS-1:0] tag;
  logic [CNT_BITS-1:0] cnt;
  logic [DAT_BITS+1:0] t_sum;
  logic [DAT_BITS+1:0] t_red;
  logic                unused_sink;

  // acc < P and a < P keep t_sum below 3P, so at most one of 2P or P is subtracted
  always_comb begin
    t_sum = {1'b0, acc, 1'b0} + (b_reg[cnt] ? {2'b00, a_reg} : '0);
    if (t_sum >= P_X2) begin
      t_red = t_sum - P_X2;
    end else if (t_sum >= P_X1) begin
      t_red = t_sum - P_X1;
    end else begin
      t_red = t_sum;
    end
  end

  // Framing fields on the request side carry no meaning here; the reduced sum never reaches its top two bits
  assign unused_sink = ^{i_mul.sop, i_mul.eop, i_mul.err, i_mul.mod, t_red[DAT_BITS+1:DAT_BITS]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      i_mul.rdy <= 1'b0;
      o_mul.val <= 1'b0;
      o_mul.dat <= '0;
      o_mul.ctl <= '0;
      o_mul.sop <= 1'b0;
      o_mul.eop <= 1'b0;
      o_mul.err <= 1'b0;
      o_mul.mod <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      tag       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_mul.val && i_mul.rdy) begin
            a_reg     <= i_mul.dat[DAT_BITS-1:0];
            b_reg     <= i_mul.dat[2*DAT_BITS-1:DAT_BITS];
            tag       <= i_mul.ctl;
            acc       <= '0;
            cnt       <= CNT_TOP;
            i_mul.rdy <= 1'b0;
            state     <= RUN;
          end else begin
            i_mul.rdy <= 1'b1;
          end
        end
        RUN: begin
          acc <= t_red[DAT_BITS-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            o_mul.dat <= t_red[DAT_BITS-1:0];
            o_mul.ctl <= tag;
            o_mul.val <= 1'b1;
            o_mul.sop <= 1'b1;
            o_mul.eop <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (o_mul.rdy) begin
            o_mul.val <= 1'b0;
            o_mul.sop <= 1'b0;
            o_mul.eop <= 1'b0;
            i_mul.rdy <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_serial_resp.sv
// Self-checking bench for mod_mult_serial_resp: directed corner cases plus randomized
// traffic compared against a wide-arithmetic (a*b) % P reference.
module tb_mod_mult_serial_resp;

  localparam int DAT_BITS = 256;
  localparam int CTL_BITS = 16;
  localparam logic [DAT_BITS-1:0] P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
  localparam int N_RANDOM = 120;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  if_axi_stream #(.DAT_BYTS(2*DAT_BITS/8), .CTL_BITS(CTL_BITS)) i_mul ();
  if_axi_stream #(.DAT_BYTS(DAT_BITS/8),   .CTL_BITS(CTL_BITS)) o_mul ();

  mod_mult_serial_resp #(
    .DAT_BITS(DAT_BITS),
    .CTL_BITS(CTL_BITS),
    .P(P)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_mul(i_mul),
    .o_mul(o_mul)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DAT_BITS-1:0] golden(input logic [DAT_BITS-1:0] a, input logic [DAT_BITS-1:0] b);
    logic [2*DAT_BITS-1:0] prod;
    logic [2*DAT_BITS-1:0] rem;
    prod = {{DAT_BITS{1'b0}}, a} * {{DAT_BITS{1'b0}}, b};
    rem  = prod % {{DAT_BITS{1'b0}}, P};
    return rem[DAT_BITS-1:0];
  endfunction

  function automatic logic [DAT_BITS-1:0] rand_op();
    logic [DAT_BITS-1:0] v;
    for (int k = 0; k < DAT_BITS/32; k++) v[k*32 +: 32] = $urandom;
    return v % P;
  endfunction

  // Presents one request and waits (bounded) for it to be taken; returns #1 after the accepting edge
  task automatic send_req(input logic [DAT_BITS-1:0] a, input logic [DAT_BITS-1:0] b,
                          input logic [CTL_BITS-1:0] tag, output bit ok);
    bit hs;
    ok = 1'b0;
    @(negedge i_clk);
    i_mul.dat = {b, a};
    i_mul.ctl = tag;
    i_mul.val = 1'b1;
    for (int n = 0; n < 1000 && !ok; n++) begin
      hs = i_mul.rdy;
      @(posedge i_clk);
      if (hs) ok = 1'b1;
      else @(negedge i_clk);
    end
    #1 i_mul.val = 1'b0;
  endtask

  // Counts rising edges after the accept until o_mul.val is seen; returns at that negedge
  task automatic wait_val(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    while (!ok && lat < 2*DAT_BITS + 16) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
      if (o_mul.val === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input logic [DAT_BITS-1:0] a, input logic [DAT_BITS-1:0] b,
                         input logic [CTL_BITS-1:0] tag, output logic [DAT_BITS-1:0] dat,
                         output logic [CTL_BITS-1:0] ctl, output int lat, output bit ok);
    bit ok_req;
    bit ok_rsp;
    o_mul.rdy = 1'b1;
    send_req(a, b, tag, ok_req);
    lat = 0;
    ok_rsp = 1'b0;
    if (ok_req) wait_val(lat, ok_rsp);
    dat = o_mul.dat;
    ctl = o_mul.ctl;
    ok  = ok_req && ok_rsp;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_mul.val = 1'b0;
    i_mul.dat = '0;
    i_mul.ctl = '0;
    i_mul.sop = 1'b0;
    i_mul.eop = 1'b0;
    i_mul.err = 1'b0;
    i_mul.mod = '0;
    o_mul.rdy = 1'b0;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (i_mul.rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdy: got %b expected 0", i_mul.rdy); end
    checks++; if (o_mul.val !== 1'b0) begin failures++; $display("[TB] FAIL reset_val: got %b expected 0", o_mul.val); end
    checks++; if (o_mul.dat !== '0) begin failures++; $display("[TB] FAIL reset_dat: got %h expected 0", o_mul.dat); end
    checks++; if (o_mul.ctl !== '0) begin failures++; $display("[TB] FAIL reset_ctl: got %h expected 0", o_mul.ctl); end
    checks++;
    if ({o_mul.sop, o_mul.eop, o_mul.err} !== 3'b000 || o_mul.mod !== '0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got sop=%b eop=%b err=%b mod=%h expected all 0", o_mul.sop, o_mul.eop, o_mul.err, o_mul.mod);
    end
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (i_mul.rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy_release: got %b expected 1", i_mul.rdy); end
  endtask

  task automatic test_basic();
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    int lat;
    bit ok;
    run_txn(256'd3, 256'd5, 16'h00A5, dat, ctl, lat, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_timeout: got no response expected one"); end
    checks++; if (dat !== 256'd15) begin failures++; $display("[TB] FAIL basic_dat: got %h expected %h", dat, 256'd15); end
    checks++; if (ctl !== 16'h00A5) begin failures++; $display("[TB] FAIL basic_ctl: got %h expected 00a5", ctl); end
    checks++; if (lat != DAT_BITS) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, DAT_BITS); end
    checks++;
    if (o_mul.val !== 1'b0 || i_mul.rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_after_hs: got val=%b rdy=%b expected val=0 rdy=1", o_mul.val, i_mul.rdy);
    end
  endtask

  task automatic test_boundaries();
    logic [DAT_BITS-1:0] a_tab [4];
    logic [DAT_BITS-1:0] b_tab [4];
    logic [DAT_BITS-1:0] e_tab [4];
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    int lat;
    bit ok;
    a_tab[0] = P - 1; b_tab[0] = P - 1; e_tab[0] = 256'd1;
    a_tab[1] = P - 1; b_tab[1] = 256'd2; e_tab[1] = P - 2;
    a_tab[2] = '0;    b_tab[2] = P - 1; e_tab[2] = '0;
    a_tab[3] = 256'd12345; b_tab[3] = 256'd1; e_tab[3] = 256'd12345;
    for (int i = 0; i < 4; i++) begin
      run_txn(a_tab[i], b_tab[i], CTL_BITS'(16'h1100 + i), dat, ctl, lat, ok);
      checks++;
      if (!ok || dat !== e_tab[i] || ctl !== CTL_BITS'(16'h1100 + i)) begin
        failures++;
        $display("[TB] FAIL boundary_%0d: got ok=%b dat=%h ctl=%h expected dat=%h ctl=%h",
                 i, ok, dat, ctl, e_tab[i], CTL_BITS'(16'h1100 + i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DAT_BITS-1:0] a0, b0, a1, b1, d0;
    logic [CTL_BITS-1:0] c0;
    int lat;
    int bad;
    bit ok;
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
    o_mul.rdy = 1'b0;
    send_req(a0, b0, 16'h5A01, ok);
    // Second request held on the bus for the whole job; it must wait for the handshake
    i_mul.dat = {b1, a1};
    i_mul.ctl = 16'h5A02;
    i_mul.val = 1'b1;
    lat = 0;
    if (ok) wait_val(lat, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_timeout: got no response expected one"); end
    d0 = o_mul.dat;
    c0 = o_mul.ctl;
    checks++; if (d0 !== golden(a0, b0)) begin failures++; $display("[TB] FAIL bp_dat: got %h expected %h", d0, golden(a0, b0)); end
    checks++; if (c0 !== 16'h5A01) begin failures++; $display("[TB] FAIL bp_ctl: got %h expected 5a01", c0); end
    checks++;
    if ({o_mul.sop, o_mul.eop, o_mul.err} !== 3'b110 || o_mul.mod !== '0) begin
      failures++;
      $display("[TB] FAIL bp_flags: got sop=%b eop=%b err=%b mod=%h expected 1 1 0 0", o_mul.sop, o_mul.eop, o_mul.err, o_mul.mod);
    end
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_mul.val !== 1'b1 || o_mul.dat !== d0 || o_mul.ctl !== c0 || i_mul.rdy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    o_mul.rdy = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_mul.val !== 1'b0 || i_mul.rdy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release: got val=%b rdy=%b expected val=0 rdy=1", o_mul.val, i_mul.rdy);
    end
    @(posedge i_clk);
    #1 i_mul.val = 1'b0;
    wait_val(lat, ok);
    checks++;
    if (!ok || lat != DAT_BITS || o_mul.dat !== golden(a1, b1) || o_mul.ctl !== 16'h5A02) begin
      failures++;
      $display("[TB] FAIL back_to_back: got ok=%b lat=%0d dat=%h ctl=%h expected lat=%0d dat=%h ctl=5a02",
               ok, lat, o_mul.dat, o_mul.ctl, DAT_BITS, golden(a1, b1));
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_run();
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    int lat;
    int seen;
    bit ok;
    o_mul.rdy = 1'b1;
    send_req(rand_op(), rand_op(), 16'hBEEF, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL midrst_accept: got no accept expected accept"); end
    repeat (100) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_mul.val !== 1'b0 || i_mul.rdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_state: got val=%b rdy=%b expected 0 0", o_mul.val, i_mul.rdy);
    end
    i_rst = 1'b0;
    seen = 0;
    repeat (DAT_BITS + 44) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_mul.val !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("[TB] FAIL midrst_no_resp: got %0d val cycles expected 0", seen); end
    run_txn(256'd7, 256'd9, 16'h0C0D, dat, ctl, lat, ok);
    checks++;
    if (!ok || dat !== 256'd63 || ctl !== 16'h0C0D) begin
      failures++;
      $display("[TB] FAIL midrst_next: got ok=%b dat=%h ctl=%h expected dat=%h ctl=0c0d", ok, dat, ctl, 256'd63);
    end
  endtask

  task automatic test_random();
    logic [DAT_BITS+CTL_BITS-1:0] exp_q [$];
    logic [DAT_BITS+CTL_BITS-1:0] exp_v;
    logic [DAT_BITS-1:0] a, b;
    logic [CTL_BITS-1:0] tag;
    int lat;
    bit ok;
    bit r;
    bit done;
    tag = 16'h2000;
    for (int i = 0; i < N_RANDOM; i++) begin
      a = rand_op();
      b = rand_op();
      if (i % 17 == 3) a = '0;
      if (i % 19 == 5) b = 256'd1;
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      i_mul.sop = 1'($urandom);
      i_mul.eop = 1'($urandom);
      i_mul.err = 1'($urandom);
      i_mul.mod = 6'($urandom);
      o_mul.rdy = 1'($urandom);
      exp_q.push_back({tag, golden(a, b)});
      send_req(a, b, tag, ok);
      lat = 0;
      if (ok) wait_val(lat, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL rand_timeout_%0d: got no response expected one", i);
      end else begin
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
          r = 1'($urandom_range(0, 1));
          o_mul.rdy = r;
          if (r) begin
            exp_v = exp_q.pop_front();
            if (o_mul.dat !== exp_v[DAT_BITS-1:0] || o_mul.ctl !== exp_v[DAT_BITS+CTL_BITS-1:DAT_BITS]) begin
              failures++;
              $display("[TB] FAIL rand_%0d: got dat=%h ctl=%h expected dat=%h ctl=%h", i, o_mul.dat, o_mul.ctl,
                       exp_v[DAT_BITS-1:0], exp_v[DAT_BITS+CTL_BITS-1:DAT_BITS]);
            end
            done = 1'b1;
          end
          @(posedge i_clk);
          @(negedge i_clk);
        end
        if (!done) begin
          failures++;
          $display("[TB] FAIL rand_hs_%0d: got no handshake expected one", i);
        end
      end
      tag = tag + 1'b1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_leftover: got %0d pending expected 0", exp_q.size());
    end
    i_mul.sop = 1'b0;
    i_mul.eop = 1'b0;
    i_mul.err = 1'b0;
    i_mul.mod = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
